// File: rtl/acumulador_4_bit.sv
// Sequential operand feeder / result collector wrapped around a combinational WIDTH-bit adder.
// Accepts a job of len operands, accumulates modulo 2^WIDTH and reports a sticky carry flag.
module acumulador_4_bit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH:0]   add_s,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StAdd, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] op_q;
    logic             ovf_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remaining_q;
    logic             out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    state_d = StAdd;
                end
            end
            StAdd: begin
                state_d = (remaining_q == CNT_W'(1)) ? StDone : StLoad;
            end
            StDone: begin
                // Only leave once the result has actually been offered.
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            op_q        <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q       <= '0;
                        op_q        <= '0;
                        ovf_q       <= 1'b0;
                        count_q     <= '0;
                        remaining_q <= len;
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        op_q    <= in_data;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                StAdd: begin
                    // Carry is never fed back; it only sets the sticky flag.
                    acc_q       <= add_s[WIDTH-1:0];
                    ovf_q       <= ovf_q | add_s[WIDTH];
                    remaining_q <= remaining_q - CNT_W'(1);
                end
                default: ;
            endcase

            if (state_q == StDone) begin
                out_valid_q <= !(out_valid_q && out_ready);
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        in_ready = (state_q == StLoad);
        busy     = (state_q != StIdle);
    end

    assign add_a     = acc_q;
    assign add_b     = op_q;
    assign add_cin   = 1'b0;
    assign result    = acc_q;
    assign overflow  = ovf_q;
    assign count     = count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_acumulador_4_bit.sv
// Directed bench for acumulador_4_bit; a behavioural adder closes the add_a/add_b -> add_s loop.
module tb_acumulador_4_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [4:0] add_s;
    logic [3:0] result;
    logic       overflow;
    logic [3:0] count;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int c0    = 0;

    always #5 clk = ~clk;

    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    acumulador_4_bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .result    (result),
        .overflow  (overflow),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_job(input logic [3:0] n);
        start = 1'b1;
        len   = n;
        tick();
        c0    = cyc;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input int gap);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("in_ready_wait", in_ready, 1);
        tick();
    endtask

    task automatic wait_out(output int lat);
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        check("out_valid_wait", out_valid, 1);
        lat = cyc - c0;
    endtask

    task automatic run2(input logic [3:0] a, input logic [3:0] b);
        int  lat;
        int  sum;
        sum = int'(a) + int'(b);
        begin_job(4'd2);
        send(a, 0);
        send(b, 0);
        wait_out(lat);
        check("pair_result", result, sum % 16);
        check("pair_overflow", overflow, (sum > 15) ? 1 : 0);
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", count, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);
        rst = 1'b0;
        tick();

        // len=3: 3+4+5
        begin_job(4'd3);
        check("j1_busy", busy, 1);
        check("j1_in_ready", in_ready, 1);
        send(4'd3, 0);
        check("j1_add_b", add_b, 3);
        send(4'd4, 0);
        send(4'd5, 0);
        wait_out(lat);
        check("j1_latency", lat, 7);
        check("j1_result", result, 12);
        check("j1_overflow", overflow, 0);
        check("j1_count", count, 3);
        check("j1_add_cin", add_cin, 0);
        tick();
        check("j1_out_valid_drop", out_valid, 0);
        check("j1_idle_busy", busy, 0);
        check("j1_idle_result", result, 12);
        check("j1_idle_count", count, 3);
        in_valid = 1'b0;

        // len=2: 9+9 wraps
        begin_job(4'd2);
        send(4'd9, 0);
        send(4'd9, 0);
        wait_out(lat);
        check("j2_result", result, 2);
        check("j2_overflow", overflow, 1);
        tick();
        check("j2_idle_overflow", overflow, 1);

        // len=1: flag cleared by start
        begin_job(4'd1);
        check("j3_overflow_cleared", overflow, 0);
        send(4'd15, 0);
        wait_out(lat);
        check("j3_latency", lat, 3);
        check("j3_result", result, 15);
        check("j3_overflow", overflow, 0);
        tick();

        // len=0: straight to DONE, operand stream ignored
        in_valid = 1'b1;
        in_data  = 4'd7;
        out_ready = 1'b0;
        begin_job(4'd0);
        check("j4_busy", busy, 1);
        check("j4_out_valid_early", out_valid, 0);
        check("j4_in_ready_a", in_ready, 0);
        tick();
        check("j4_out_valid", out_valid, 1);
        check("j4_in_ready_b", in_ready, 0);
        check("j4_result", result, 0);
        check("j4_count", count, 0);
        check("j4_overflow", overflow, 0);
        out_ready = 1'b1;
        tick();
        check("j4_out_valid_drop", out_valid, 0);
        in_valid = 1'b0;

        // len=2: 7,8 with gaps, back-pressure, stray starts
        out_ready = 1'b0;
        begin_job(4'd2);
        send(4'd7, 3);
        start = 1'b1;
        len   = 4'd5;
        tick();
        start = 1'b0;
        send(4'd8, 3);
        in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            check("j5_hold_valid", out_valid, 1);
            check("j5_hold_result", result, 15);
            tick();
        end
        start = 1'b0;
        check("j5_still_valid", out_valid, 1);
        check("j5_count", count, 2);
        out_ready = 1'b1;
        tick();
        check("j5_out_valid_drop", out_valid, 0);
        check("j5_idle", busy, 0);
        check("j5_idle_result", result, 15);

        // len=4: reset during second ADD, then a clean len=1 job
        begin_job(4'd4);
        send(4'd1, 0);
        send(4'd2, 0);
        check("j6_pre_rst_add_a", add_a, 1);
        rst = 1'b1;
        #1;
        check("j6_rst_busy", busy, 0);
        check("j6_rst_in_ready", in_ready, 0);
        check("j6_rst_out_valid", out_valid, 0);
        check("j6_rst_result", result, 0);
        check("j6_rst_count", count, 0);
        check("j6_rst_overflow", overflow, 0);
        check("j6_rst_add_a", add_a, 0);
        check("j6_rst_add_b", add_b, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("j6_idle_after_rst", busy, 0);
        begin_job(4'd1);
        send(4'd6, 0);
        wait_out(lat);
        check("j7_result", result, 6);
        check("j7_overflow", overflow, 0);
        check("j7_count", count, 1);
        tick();

        // all operand pairs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run2(4'(a), 4'(b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
